gray_sync_rx: RTL and testbench



---
 rtl/gray_sync_rx.sv | 135 +++++++++++++
 tb/tb_gray_sync_rx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/gray_sync_rx.sv
// Receive-side stage for gray-coded counters/pointers from a foreign clock domain.
// Resynchronises the gray bus, decodes it to binary, reports per-cycle movement
// (changed pulse + modular delta) and flags illegal multi-bit transitions.
//
// Ports:
//   clk          local clock (only clock in the block)
//   reset        synchronous, active-high reset
//   gray_in      asynchronous gray-coded input bus
//   bin_out      binary decode of the last accepted sample
//   gray_out     last accepted gray sample (reference)
//   changed      one-cycle pulse when an accepted sample differs from the reference
//   delta        (new_bin - old_bin) mod 2^WIDTH when changed, else 0
//   error        sticky flag, set by an accepted transition of Hamming distance > 1
//   error_clear  synchronous clear of error (a simultaneous set wins)
//   primed       high once the reference has been loaded after reset
module gray_sync_rx #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             changed,
  output logic [WIDTH-1:0] delta,
  output logic             error,
  input  logic             error_clear,
  output logic             primed
);

  localparam int unsigned CntW = (SYNC_STAGES > 1) ? $clog2(SYNC_STAGES) : 1;
  localparam logic [CntW-1:0] FillLast = CntW'(SYNC_STAGES - 1);

  typedef enum logic [1:0] {StFill, StPrime, StTrack} state_e;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] g_s;
  logic [WIDTH-1:0] bin_s;
  logic [WIDTH-1:0] diff;
  logic             multi_bit;

  state_e           state_q;
  logic [CntW-1:0]  fill_cnt_q;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             changed_q;
  logic [WIDTH-1:0] delta_q;
  logic             error_q;
  logic             primed_q;

  // Synchroniser chain; stage 0 is the only register that sees the async bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign g_s = sync_q[SYNC_STAGES-1];

  // Gray to binary: bit i is the XOR of all gray bits at or above i.
  always_comb begin
    bin_s = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      bin_s[i] = ^(g_s >> i);
    end
  end

  // More than one bit differs iff clearing the lowest set bit leaves something.
  assign diff      = g_s ^ gray_q;
  assign multi_bit = (diff & (diff - WIDTH'(1))) != '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StFill;
      fill_cnt_q <= '0;
      bin_q      <= '0;
      gray_q     <= '0;
      changed_q  <= 1'b0;
      delta_q    <= '0;
      error_q    <= 1'b0;
      primed_q   <= 1'b0;
    end else begin
      changed_q <= 1'b0;
      delta_q   <= '0;
      if (error_clear) begin
        error_q <= 1'b0;
      end
      case (state_q)
        StFill: begin
          // Wait until the chain holds samples taken after reset release.
          if (fill_cnt_q == FillLast) begin
            state_q <= StPrime;
          end else begin
            fill_cnt_q <= fill_cnt_q + CntW'(1);
          end
        end
        StPrime: begin
          gray_q   <= g_s;
          bin_q    <= bin_s;
          primed_q <= 1'b1;
          state_q  <= StTrack;
        end
        StTrack: begin
          if (g_s != gray_q) begin
            // Illegal jumps are still accepted so the tracker never stalls.
            gray_q    <= g_s;
            bin_q     <= bin_s;
            changed_q <= 1'b1;
            delta_q   <= bin_s - bin_q;
            if (multi_bit) begin
              error_q <= 1'b1; // later assignment: set beats a same-cycle clear
            end
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign changed  = changed_q;
  assign delta    = delta_q;
  assign error    = error_q;
  assign primed   = primed_q;

endmodule

// File: tb/tb_gray_sync_rx.sv
module tb_gray_sync_rx;

  localparam int unsigned W = 4;
  localparam int unsigned S = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] gray_in;
  logic         error_clear;
  logic [W-1:0] bin_out, gray_out, delta;
  logic         changed, error, primed;

  int checks = 0;
  int errors = 0;

  gray_sync_rx #(
    .WIDTH      (W),
    .SYNC_STAGES(S)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .gray_in    (gray_in),
    .bin_out    (bin_out),
    .gray_out   (gray_out),
    .changed    (changed),
    .delta      (delta),
    .error      (error),
    .error_clear(error_clear),
    .primed     (primed)
  );

  always #5 clk = ~clk;

  // Reference model: edges counted since reset release, raw input history in a queue.
  logic [W-1:0] m_bin, m_gray, m_delta;
  logic         m_changed, m_err, m_primed;
  int           m_edges;
  logic [W-1:0] hist[$];

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int s = 1; s < int'(W); s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic [W-1:0] gi, input logic ec);
    logic [W-1:0] g;
    logic         nerr;
    if (rst) begin
      m_bin = '0; m_gray = '0; m_delta = '0;
      m_changed = 1'b0; m_err = 1'b0; m_primed = 1'b0;
      m_edges = 0;
      hist.delete();
    end else begin
      g = (hist.size() == int'(S)) ? hist[0] : '0; // sample taken S edges ago
      m_edges++;
      m_changed = 1'b0;
      m_delta = '0;
      nerr = ec ? 1'b0 : m_err;
      if (m_edges == int'(S) + 1) begin
        m_gray = g; m_bin = g2b(g); m_primed = 1'b1;
      end else if (m_edges > int'(S) + 1 && g != m_gray) begin
        m_changed = 1'b1;
        m_delta = g2b(g) - m_bin;
        if ($countones(g ^ m_gray) > 1) nerr = 1'b1;
        m_gray = g;
        m_bin = g2b(g);
      end
      m_err = nerr;
      hist.push_back(gi);
      if (hist.size() > int'(S)) void'(hist.pop_front());
    end
  endtask

  // One clock edge: update the model with the inputs the DUT sees, then compare.
  task automatic tick();
    logic         r, ec;
    logic [W-1:0] gi;
    r = reset; gi = gray_in; ec = error_clear;
    @(posedge clk);
    model_edge(r, gi, ec);
    #1;
    check("bin_out", 32'(bin_out), 32'(m_bin));
    check("gray_out", 32'(gray_out), 32'(m_gray));
    check("changed", 32'(changed), 32'(m_changed));
    check("delta", 32'(delta), 32'(m_delta));
    check("error", 32'(error), 32'(m_err));
    check("primed", 32'(primed), 32'(m_primed));
  endtask

  task automatic reset_and_prime(input logic [W-1:0] g);
    reset = 1'b1; gray_in = g; error_clear = 1'b0;
    tick(); tick();
    reset = 1'b0;
    repeat (S + 1) tick();
  endtask

  // Change input, then wait for the accepting edge (S+1 edges later).
  task automatic step_and_settle(input logic [W-1:0] g);
    gray_in = g;
    repeat (S + 1) tick();
  endtask

  logic [W-1:0] cur_b;
  logic [W-1:0] up_seq [4];

  initial begin
    reset = 1'b1; gray_in = '0; error_clear = 1'b0;

    // Prime with a value held through reset release.
    reset_and_prime(4'b0111);
    check("prime_primed", 32'(primed), 32'd1);
    check("prime_bin", 32'(bin_out), 32'd5);
    check("prime_gray", 32'(gray_out), 32'b0111);
    check("prime_changed", 32'(changed), 32'd0);
    repeat (3) tick();

    // Count up one gray step at a time.
    reset_and_prime(4'b0000);
    up_seq[0] = 4'b0001; up_seq[1] = 4'b0011; up_seq[2] = 4'b0010; up_seq[3] = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      step_and_settle(up_seq[k]);
      check("up_changed", 32'(changed), 32'd1);
      check("up_delta", 32'(delta), 32'd1);
      check("up_bin", 32'(bin_out), 32'(k + 1));
      tick();
    end
    check("up_error", 32'(error), 32'd0);

    // Wrap forward then step back.
    reset_and_prime(4'b1000);
    check("wrap_prime_bin", 32'(bin_out), 32'd15);
    step_and_settle(4'b0000);
    check("wrap_bin", 32'(bin_out), 32'd0);
    check("wrap_delta", 32'(delta), 32'd1);
    tick();
    step_and_settle(4'b1000);
    check("rev_bin", 32'(bin_out), 32'd15);
    check("rev_delta", 32'(delta), 32'd15);
    check("rev_error", 32'(error), 32'd0);

    // Illegal jumps, clear collision, plain clear.
    reset_and_prime(4'b0000);
    step_and_settle(4'b0011);
    check("ill_changed", 32'(changed), 32'd1);
    check("ill_bin", 32'(bin_out), 32'd2);
    check("ill_delta", 32'(delta), 32'd2);
    check("ill_error", 32'(error), 32'd1);
    tick();
    gray_in = 4'b1100;
    repeat (S) tick();
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    check("set_wins_error", 32'(error), 32'd1);
    check("set_wins_bin", 32'(bin_out), 32'd8);
    tick();
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    check("clear_error", 32'(error), 32'd0);

    // Hold.
    repeat (20) tick();

    // Mid-run reset while tracking 9.
    step_and_settle(b2g(4'd9));
    check("pre_rst_bin", 32'(bin_out), 32'd9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_bin", 32'(bin_out), 32'd0);
    check("rst_primed", 32'(primed), 32'd0);
    repeat (S + 1) tick();
    check("reprime_bin", 32'(bin_out), 32'd9);
    check("reprime_changed", 32'(changed), 32'd0);
    check("reprime_error", 32'(error), 32'd0);

    // Randomised walk: mostly legal +/-1 steps, some jumps, holds, clears and resets.
    cur_b = 4'd9;
    for (int it = 0; it < 400; it++) begin
      int sel;
      sel = int'($urandom_range(99));
      if (sel < 40)      cur_b = cur_b + 4'd1;
      else if (sel < 65) cur_b = cur_b - 4'd1;
      else if (sel < 80) cur_b = W'($urandom);
      gray_in = b2g(cur_b);
      error_clear = ($urandom_range(9) == 0);
      reset = ($urandom_range(99) == 0);
      repeat ($urandom_range(1, 5)) tick();
      reset = 1'b0;
      error_clear = 1'b0;
    end
    repeat (S + 3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
